instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
Instruction queue between the fetch stage and the decode stage of the pipelined core. Each valid fetch beat is captured as a {instr, PC, PC+4} bundle in a circular FIFO and presented to decode in order. Decode stalls are absorbed without freezing the PC. A taken branch or jump in Execute flushes all queued (wrong-path) instructions.

Parameters:
DATA_WIDTH, 32, width of instruction, PC and PC+4 fields
DEPTH, 4, number of queue entries; power of two, minimum 2
NOP, 32'h00000013, instruction word driven to decode when the queue is empty (addi x0,x0,0)

Ports:
clk  input  1  core clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset; queue cleared while low
validF  input  1  fetch presents a valid instruction this cycle
instrF  input  DATA_WIDTH  fetched instruction word
PCF  input  DATA_WIDTH  PC of fetched instruction
PCPlus4F  input  DATA_WIDTH  PCF+4 from fetch
readyF  output  1  queue can accept a push; drives fetch enable
stallD  input  1  decode/hazard unit holds the head entry
flushD  input  1  PCSrcE from Execute; discard all entries
validD  output  1  head entry valid
instrD  output  DATA_WIDTH  head instruction, NOP when empty
PCD  output  DATA_WIDTH  head PC, 0 when empty
PCPlus4D  output  DATA_WIDTH  head PC+4, 0 when empty
countQ  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH entries of {instr, PC, PC+4}. Write pointer, read pointer and count registers; pointers wrap modulo DEPTH.
- Reset (reset=0, asynchronous): pointers=0, count=0. Outputs: validD=0, instrD=NOP, PCD=0, PCPlus4D=0, readyF=1, countQ=0. Storage contents need not be cleared.
- readyF = (count != DEPTH). Combinational from count only; it does not depend on a same-cycle pop, so there is no ready/valid combinational loop.
- push = validF & readyF & ~flushD. On push, write the entry at the write pointer and increment the write pointer.
- pop = validD & ~stallD & ~flushD. On pop, increment the read pointer.
- count update: +1 on push only, -1 on pop only, unchanged when push and pop occur together.
- validD = (count != 0). instrD/PCD/PCPlus4D come combinationally from the entry at the read pointer when validD=1; otherwise NOP/0/0.
- Latency: a push at edge N is visible at the head after edge N when the queue was empty. There is no same-cycle bypass from F to D.
- Flush (flushD=1): at the next edge, pointers=0 and count=0. An incoming push and any pop in that cycle are discarded. validD drops to 0 in the following cycle. Flush has priority over stallD and validF.
- Full, validF=1, no flush: no write. Fetch must hold its PC (readyF=0 drives enable low).
- Full with a pop in the same cycle: pop only, count becomes DEPTH-1, readyF=1 next cycle.
- Empty with stallD=1: no effect. validD stays 0 and NOP is driven.
- Pointer wrap: when a pointer reaches DEPTH-1 and increments, it returns to 0 with no loss of ordering.
- Reset asserted mid-operation: the queue empties immediately (asynchronously). The first push after reset release goes to entry 0.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then release with validF=0 -> validD=0, instrD=32'h00000013, readyF=1, countQ=0.
- Streaming: push PC=0x00,0x04,0x08 with stallD=0 -> after one cycle of latency, decode sees PCD 0x00,0x04,0x08 in order with PCPlus4D=PCD+4; countQ stays at 1.
- Fill under stall: stallD=1 while pushing 5 instructions at PC 0x10..0x20 with DEPTH=4 -> countQ=4, readyF=0, 5th (PC 0x20) is not written. After stallD=0, decode sees 0x10,0x14,0x18,0x1C, then 0x20 once fetch re-presents it.
- Simultaneous push/pop when full: count=4, validF=1, stallD=0 -> pop only, countQ=3, the incoming instruction is not captured that cycle.
- Flush: queue holds 3 entries, flushD=1 with validF=1 (PC 0x40) -> next cycle countQ=0, validD=0, instrD=NOP. The next push (PC 0x80) appears at the head with PCD=0x80.
- Wrap plus async reset: stream 10 instructions through with random stallD and check order matches push order. Then assert reset mid-stream (between edges) -> validD=0 immediately; after release, the first push is read back correctly.

Source files
------------

// File: rtl/instr_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
// The queue takes the slave modport; the pipeline side (or a bench) takes master.
interface instr_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  validF;
  logic [DATA_WIDTH-1:0] instrF;
  logic [DATA_WIDTH-1:0] PCF;
  logic [DATA_WIDTH-1:0] PCPlus4F;
  logic                  readyF;
  logic                  stallD;
  logic                  flushD;
  logic                  validD;
  logic [DATA_WIDTH-1:0] instrD;
  logic [DATA_WIDTH-1:0] PCD;
  logic [DATA_WIDTH-1:0] PCPlus4D;
  logic [CW-1:0]         countQ;

  modport slave (
    input  validF, instrF, PCF, PCPlus4F, stallD, flushD,
    output readyF, validD, instrD, PCD, PCPlus4D, countQ
  );

  modport master (
    output validF, instrF, PCF, PCPlus4F, stallD, flushD,
    input  readyF, validD, instrD, PCD, PCPlus4D, countQ
  );
endinterface

// File: rtl/instr_queue.sv
// Circular FIFO of {instr, PC, PC+4} between fetch and decode.
// Absorbs decode stalls; a taken branch in Execute flushes every queued entry.
module instr_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] NOP        = 32'h00000013
) (
  input  logic          clk,
  input  logic          reset,
  instr_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [DATA_WIDTH-1:0] pc4_mem_q   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic ready;
  logic valid;
  logic push;
  logic pop;

  // Ready looks only at the registered count, so it never depends on stallD.
  assign ready = (count_q != FULL);
  assign valid = (count_q != '0);
  assign push  = q.validF & ready & ~q.flushD;
  assign pop   = valid & ~q.stallD & ~q.flushD;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flushD) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= q.instrF;
      pc_mem_q[wr_ptr_q]    <= q.PCF;
      pc4_mem_q[wr_ptr_q]   <= q.PCPlus4F;
    end
  end

  assign q.readyF   = ready;
  assign q.validD   = valid;
  assign q.countQ   = count_q;
  assign q.instrD   = valid ? instr_mem_q[rd_ptr_q] : NOP;
  assign q.PCD      = valid ? pc_mem_q[rd_ptr_q]    : '0;
  assign q.PCPlus4D = valid ? pc4_mem_q[rd_ptr_q]   : '0;
endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_instr_queue;
  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc4;
  } ent_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  ent_t mq[$];
  logic [31:0] fetch_pc;

  instr_queue_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) b ();

  instr_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (mq.size() != 0);
    chk("readyF", 32'(b.readyF), 32'(mq.size() != DEPTH));
    chk("validD", 32'(b.validD), 32'(ev));
    chk("countQ", 32'(b.countQ), 32'(mq.size()));
    chk("instrD",   b.instrD,   ev ? mq[0].ins : NOP);
    chk("PCD",      b.PCD,      ev ? mq[0].pc  : 32'h0);
    chk("PCPlus4D", b.PCPlus4D, ev ? mq[0].pc4 : 32'h0);
  endtask

  // One cycle: drive inputs just after a falling edge, check, advance the model.
  task automatic step(input logic vf, input logic [31:0] ins, input logic [31:0] pc,
                      input logic st, input logic fl, output logic accepted);
    logic pu, po;
    ent_t e;
    b.validF   = vf;
    b.instrF   = ins;
    b.PCF      = pc;
    b.PCPlus4F = pc + 32'd4;
    b.stallD   = st;
    b.flushD   = fl;
    #1;
    check_outputs();
    pu = vf && (mq.size() != DEPTH) && !fl;
    po = (mq.size() != 0) && !st && !fl;
    if (fl) mq.delete();
    else begin
      if (po) void'(mq.pop_front());
      if (pu) begin
        e.ins = ins; e.pc = pc; e.pc4 = pc + 32'd4;
        mq.push_back(e);
      end
    end
    accepted = pu;
    @(negedge clk);
  endtask

  // Fetch model: presents fetch_pc, advances only when the queue took it.
  task automatic fetch(input logic vf, input logic st, input logic fl);
    logic acc;
    step(vf, $urandom() ^ fetch_pc, fetch_pc, st, fl, acc);
    if (acc) fetch_pc = fetch_pc + 32'd4;
  endtask

  task automatic idle(input logic st);
    logic acc;
    step(1'b0, 32'h0, 32'h0, st, 1'b0, acc);
  endtask

  initial begin
    total = 0;
    bad = 0;
    fetch_pc = 0;
    b.validF = 0; b.instrF = 0; b.PCF = 0; b.PCPlus4F = 0;
    b.stallD = 0; b.flushD = 0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Reset then idle
    idle(1'b0);
    idle(1'b0);

    // Streaming PC 0x00, 0x04, 0x08
    fetch_pc = 32'h0;
    repeat (3) fetch(1'b1, 1'b0, 1'b0);
    repeat (2) idle(1'b0);

    // Fill under stall: fifth fetch (0x20) must be refused
    fetch_pc = 32'h10;
    repeat (5) fetch(1'b1, 1'b1, 1'b0);
    chk("held_pc", fetch_pc, 32'h20);
    // Full with pop and pending push: pop only, then drain with re-presented 0x20
    repeat (3) fetch(1'b1, 1'b0, 1'b0);
    repeat (6) idle(1'b0);

    // Flush with three entries and an incoming push
    fetch_pc = 32'h30;
    repeat (3) fetch(1'b1, 1'b1, 1'b0);
    fetch_pc = 32'h40;
    fetch(1'b1, 1'b0, 1'b1);
    fetch_pc = 32'h80;
    fetch(1'b1, 1'b1, 1'b0);
    idle(1'b1);
    repeat (2) idle(1'b0);

    // Random traffic exercises pointer wrap and ordering
    fetch_pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      logic vf, st, fl;
      vf = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 29) == 0);
      fetch(vf, st, fl);
      if (fl) fetch_pc = {$urandom_range(0, 32'h3fff), 2'b00};
    end

    // Asynchronous reset mid-stream
    fetch_pc = 32'h200;
    repeat (3) fetch(1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    mq.delete();
    chk("rst_validD", 32'(b.validD), 32'h0);
    chk("rst_countQ", 32'(b.countQ), 32'h0);
    chk("rst_readyF", 32'(b.readyF), 32'h1);
    chk("rst_instrD", b.instrD, NOP);
    chk("rst_PCD",    b.PCD,    32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    fetch_pc = 32'h300;
    fetch(1'b1, 1'b0, 1'b0);
    fetch(1'b0, 1'b1, 1'b0);
    chk("post_rst_PCD", b.PCD, 32'h300);
    repeat (2) idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
